// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin responder that serves the instruction fetch port and
//            the data port from one synchronous single-port SRAM, with a
//            configurable number of wait states per access.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_WIDTH  = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] instr_m_addr,
  input  logic                  instr_m_access,
  output logic                  instr_m_ack,
  output logic [15:0]           instr_m_data_in,
  input  logic [ADDR_WIDTH-1:0] data_m_addr,
  input  logic [15:0]           data_m_data_out,
  input  logic                  data_m_access,
  input  logic                  data_m_wr_en,
  input  logic [1:0]            data_m_bytesel,
  output logic                  data_m_ack,
  output logic [15:0]           data_m_data_in,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_cs,
  output logic                  sram_wr_en,
  output logic [1:0]            sram_bytesel,
  output logic [15:0]           sram_wdata,
  input  logic [15:0]           sram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic       PORT_INSTR = 1'b0;
  localparam logic       PORT_DATA  = 1'b1;
  localparam logic [3:0] WS_INIT    = 4'(WAIT_STATES);

  state_t                  state_q, state_d;
  logic                    port_q, port_d;
  logic                    last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_q, wr_d;
  logic [1:0]              bsel_q, bsel_d;
  logic [15:0]             wdata_q, wdata_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [15:0]             ihold_q, ihold_d;
  logic [15:0]             dhold_q, dhold_d;
  logic                    grant_data;

  // State and request registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      port_q       <= PORT_INSTR;
      last_grant_q <= PORT_INSTR;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      bsel_q       <= 2'b00;
      wdata_q      <= 16'h0000;
      cnt_q        <= 4'd0;
      ihold_q      <= 16'h0000;
      dhold_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      bsel_q       <= bsel_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      ihold_q      <= ihold_d;
      dhold_q      <= dhold_d;
    end
  end

  // Data wins a tie unless it was the previous winner, so a tie right after
  // reset goes to data and continuous ties alternate.
  assign grant_data = data_m_access &&
                      (!instr_m_access || (last_grant_q == PORT_INSTR));

  // Next-state logic: grant in IDLE, count wait states in BUSY, capture read
  // data in ACK, then always drop back to IDLE for one sampling cycle.
  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    bsel_d       = bsel_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    ihold_d      = ihold_q;
    dhold_d      = dhold_q;
    case (state_q)
      IDLE: begin
        if (instr_m_access || data_m_access) begin
          state_d = BUSY;
          cnt_d   = WS_INIT;
          if (grant_data) begin
            port_d       = PORT_DATA;
            last_grant_d = PORT_DATA;
            addr_d       = data_m_addr;
            wr_d         = data_m_wr_en;
            bsel_d       = data_m_bytesel;
            wdata_d      = data_m_data_out;
          end else begin
            port_d       = PORT_INSTR;
            last_grant_d = PORT_INSTR;
            addr_d       = instr_m_addr;
            wr_d         = 1'b0;
            bsel_d       = 2'b11;
            wdata_d      = 16'h0000;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
        if (!wr_q) begin
          if (port_q == PORT_DATA) begin
            dhold_d = sram_rdata;
          end else begin
            ihold_d = sram_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM side: select held through ACK so read data arrives in that cycle.
  assign sram_cs      = (state_q == BUSY) || (state_q == ACK);
  assign sram_addr    = addr_q;
  assign sram_bytesel = bsel_q;
  assign sram_wdata   = wdata_q;
  assign sram_wr_en   = (state_q == BUSY) && (cnt_q == 4'd0) && wr_q;

  // Port side: ack pulse to the winner; read data bypasses the hold register
  // during the ack of a read.
  assign instr_m_ack     = (state_q == ACK) && (port_q == PORT_INSTR);
  assign data_m_ack      = (state_q == ACK) && (port_q == PORT_DATA);
  assign instr_m_data_in = (instr_m_ack && !wr_q) ? sram_rdata : ihold_q;
  assign data_m_data_in  = (data_m_ack && !wr_q) ? sram_rdata : dhold_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          errors = 0;

  // DUT with zero wait states
  logic [18:0] ia, da, sa;
  logic        iacc, dacc, dwe, iack, dack, scs, swe;
  logic [15:0] dwd, idin, ddin, swd, srd;
  logic [1:0]  dbs, sbs;

  // DUT with three wait states (data port only)
  logic [18:0] d3_da, d3_sa;
  logic        d3_dacc, d3_iack, d3_dack, d3_scs, d3_swe;
  logic [15:0] d3_idin, d3_ddin, d3_swd, d3_srd;
  logic [1:0]  d3_sbs;

  // SRAM models with a preload path driven by the bench
  logic [15:0] mem0 [256];
  logic [15:0] mem3 [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_STATES(0), .ADDR_WIDTH(19)) dut0 (
    .clk(clk), .reset(reset),
    .instr_m_addr(ia), .instr_m_access(iacc), .instr_m_ack(iack), .instr_m_data_in(idin),
    .data_m_addr(da), .data_m_data_out(dwd), .data_m_access(dacc), .data_m_wr_en(dwe),
    .data_m_bytesel(dbs), .data_m_ack(dack), .data_m_data_in(ddin),
    .sram_addr(sa), .sram_cs(scs), .sram_wr_en(swe), .sram_bytesel(sbs),
    .sram_wdata(swd), .sram_rdata(srd)
  );

  mem_arbiter #(.WAIT_STATES(3), .ADDR_WIDTH(19)) dut3 (
    .clk(clk), .reset(reset),
    .instr_m_addr(19'h0), .instr_m_access(1'b0), .instr_m_ack(d3_iack), .instr_m_data_in(d3_idin),
    .data_m_addr(d3_da), .data_m_data_out(16'h0), .data_m_access(d3_dacc), .data_m_wr_en(1'b0),
    .data_m_bytesel(2'b11), .data_m_ack(d3_dack), .data_m_data_in(d3_ddin),
    .sram_addr(d3_sa), .sram_cs(d3_scs), .sram_wr_en(d3_swe), .sram_bytesel(d3_sbs),
    .sram_wdata(d3_swd), .sram_rdata(d3_srd)
  );

  always @(posedge clk) begin
    if (pl_en) begin
      mem0[pl_addr] <= pl_data;
      mem3[pl_addr] <= pl_data;
    end else begin
      if (scs) begin
        if (swe && sbs[0]) mem0[sa[7:0]][7:0]  <= swd[7:0];
        if (swe && sbs[1]) mem0[sa[7:0]][15:8] <= swd[15:8];
        srd <= mem0[sa[7:0]];
      end
      if (d3_scs) begin
        d3_srd <= mem3[d3_sa[7:0]];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ia = '0; iacc = 1'b0; da = '0; dacc = 1'b0; dwe = 1'b0; dbs = 2'b00; dwd = 16'h0;
    d3_da = '0; d3_dacc = 1'b0; pl_en = 1'b0; pl_addr = 8'h0; pl_data = 16'h0;
    srd = 16'h0; d3_srd = 16'h0;
    #2;
    preload(8'h10, 16'hBEEF);
    preload(8'h11, 16'h1111);
    preload(8'h20, 16'hAAAA);
    preload(8'h30, 16'h3030);
    preload(8'h31, 16'h3131);
    preload(8'h40, 16'h4444);
    preload(8'h50, 16'h0000);
    checks++; if ({iack, dack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b expected 00", {iack, dack}); end
    checks++; if ({scs, swe} !== 2'b00) begin errors++; $display("FAIL reset_sram_ctl: got %b expected 00", {scs, swe}); end
    checks++; if ({idin, ddin} !== 32'h0) begin errors++; $display("FAIL reset_data_in: got %h expected 0", {idin, ddin}); end
    checks++; if ({sa, sbs, swd} !== 37'h0) begin errors++; $display("FAIL reset_sram_bus: got %h expected 0", {sa, sbs, swd}); end
    checks++; if ({d3_scs, d3_dack} !== 2'b00) begin errors++; $display("FAIL reset_dut3: got %b expected 00", {d3_scs, d3_dack}); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_instr_read();
    ia = 19'h00010; iacc = 1'b1;                 // cycle 0
    tick();                                       // cycle 1
    checks++; if (iack !== 1'b0) begin errors++; $display("FAIL ird_early_ack: got %b expected 0", iack); end
    checks++; if (scs !== 1'b1 || sa !== 19'h00010) begin errors++; $display("FAIL ird_busy: got cs=%b addr=%h expected cs=1 addr=00010", scs, sa); end
    tick();                                       // cycle 2
    checks++; if (iack !== 1'b1 || dack !== 1'b0) begin errors++; $display("FAIL ird_ack: got i=%b d=%b expected i=1 d=0", iack, dack); end
    checks++; if (idin !== 16'hBEEF) begin errors++; $display("FAIL ird_data: got %h expected BEEF", idin); end
    iacc = 1'b0;
    tick();                                       // cycle 3
    checks++; if (iack !== 1'b0 || dack !== 1'b0) begin errors++; $display("FAIL ird_post_ack: got i=%b d=%b expected 0 0", iack, dack); end
    tick();
    checks++; if (idin !== 16'hBEEF) begin errors++; $display("FAIL ird_hold: got %h expected BEEF", idin); end
  endtask

  task automatic test_write_bytesel();
    da = 19'h00020; dwd = 16'h1234; dbs = 2'b01; dwe = 1'b1; dacc = 1'b1;
    tick();                                       // cycle 1: single BUSY cycle
    checks++; if (swe !== 1'b1 || sbs !== 2'b01 || swd !== 16'h1234) begin errors++; $display("FAIL wr_strobe: got we=%b bs=%b wd=%h expected 1 01 1234", swe, sbs, swd); end
    tick();                                       // cycle 2
    checks++; if (dack !== 1'b1 || swe !== 1'b0) begin errors++; $display("FAIL wr_ack: got ack=%b we=%b expected 1 0", dack, swe); end
    dacc = 1'b0; dwe = 1'b0; dbs = 2'b11;
    tick();                                       // IDLE: launch read-back
    dacc = 1'b1;
    tick();
    tick();
    checks++; if (dack !== 1'b1 || ddin !== 16'hAA34) begin errors++; $display("FAIL wr_readback: got ack=%b data=%h expected 1 AA34", dack, ddin); end
    dacc = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    int nd, ni;
    nd = 0; ni = 0;
    reset = 1'b0;
    ia = 19'h00030; da = 19'h00031; dwe = 1'b0; dbs = 2'b11;
    iacc = 1'b1; dacc = 1'b1;
    tick();
    reset = 1'b1;                                 // cycle 0
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (dack) nd++;
      if (iack) ni++;
      checks++;
      if (dack !== (c == 2 || c == 8) || iack !== (c == 5 || c == 11)) begin
        errors++; $display("FAIL fair_cycle%0d: got d=%b i=%b expected d=%b i=%b", c, dack, iack, (c == 2 || c == 8), (c == 5 || c == 11));
      end
      if (c == 2) begin
        checks++; if (ddin !== 16'h3131) begin errors++; $display("FAIL fair_ddata: got %h expected 3131", ddin); end
      end
      if (c == 5) begin
        checks++; if (idin !== 16'h3030) begin errors++; $display("FAIL fair_idata: got %h expected 3030", idin); end
      end
    end
    checks++; if (nd != 2 || ni != 2) begin errors++; $display("FAIL fair_counts: got d=%0d i=%0d expected 2 2", nd, ni); end
    iacc = 1'b0; dacc = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_wait_states();
    d3_da = 19'h00040; d3_dacc = 1'b1;            // cycle 0
    checks++; if (d3_scs !== 1'b0) begin errors++; $display("FAIL ws3_cs_c0: got %b expected 0", d3_scs); end
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if (d3_scs !== (c <= 5) || d3_dack !== (c == 5)) begin
        errors++; $display("FAIL ws3_cycle%0d: got cs=%b ack=%b expected cs=%b ack=%b", c, d3_scs, d3_dack, (c <= 5), (c == 5));
      end
      if (c <= 5) begin
        checks++; if (d3_sa !== 19'h00040) begin errors++; $display("FAIL ws3_addr%0d: got %h expected 00040", c, d3_sa); end
      end
      if (c == 5) begin
        checks++; if (d3_ddin !== 16'h4444) begin errors++; $display("FAIL ws3_data: got %h expected 4444", d3_ddin); end
        d3_dacc = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    acks = 0;
    ia = 19'h00010; iacc = 1'b1;                  // cycle 0
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (iack) acks++;
      if (c == 2) begin
        checks++; if (iack !== 1'b1 || idin !== 16'hBEEF) begin errors++; $display("FAIL b2b_first: got ack=%b data=%h expected 1 BEEF", iack, idin); end
      end
      if (c == 3) begin
        checks++; if (scs !== 1'b0 || iack !== 1'b0) begin errors++; $display("FAIL b2b_gap: got cs=%b ack=%b expected 0 0", scs, iack); end
        ia = 19'h00011;
      end
      if (c == 4) begin
        checks++; if (sa !== 19'h00011) begin errors++; $display("FAIL b2b_addr: got %h expected 00011", sa); end
      end
      if (c == 5) begin
        checks++; if (iack !== 1'b1 || idin !== 16'h1111) begin errors++; $display("FAIL b2b_second: got ack=%b data=%h expected 1 1111", iack, idin); end
        iacc = 1'b0;
      end
    end
    checks++; if (acks != 2) begin errors++; $display("FAIL b2b_ack_count: got %0d expected 2", acks); end
  endtask

  task automatic test_reset_midwrite();
    int acks;
    acks = 0;
    da = 19'h00050; dwd = 16'h5555; dbs = 2'b11; dwe = 1'b1; dacc = 1'b1;
    tick();                                       // BUSY, final cycle
    checks++; if (scs !== 1'b1 || swe !== 1'b1) begin errors++; $display("FAIL rst_pre: got cs=%b we=%b expected 1 1", scs, swe); end
    #1 reset = 1'b0;
    #1;
    checks++; if (scs !== 1'b0 || swe !== 1'b0) begin errors++; $display("FAIL rst_abort: got cs=%b we=%b expected 0 0", scs, swe); end
    dwe = 1'b0; ia = 19'h00010; iacc = 1'b1;
    tick();
    if (dack || iack) acks++;
    tick();
    if (dack || iack) acks++;
    checks++; if (acks != 0) begin errors++; $display("FAIL rst_no_ack: got %0d acks expected 0", acks); end
    reset = 1'b1;                                 // cycle 0 of tie
    tick();
    tick();
    checks++; if (dack !== 1'b1 || iack !== 1'b0) begin errors++; $display("FAIL rst_tie: got d=%b i=%b expected 1 0", dack, iack); end
    checks++; if (ddin !== 16'h0000) begin errors++; $display("FAIL rst_no_write: got %h expected 0000", ddin); end
    iacc = 1'b0; dacc = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_instr_read();
    test_write_bytesel();
    test_fairness();
    test_wait_states();
    test_back_to_back();
    test_reset_midwrite();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
